// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int DATA_W  = 4;
  localparam int CNT_W   = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Circular priority pick: first set request bit scanning from ptr upward, mod 4.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);

  // Scan ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps naturally.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 x 4-bit mux, with registered
// grant, select, selected data and valid.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [DATA_W-1:0]  L0,
  input  logic [DATA_W-1:0]  L1,
  input  logic [DATA_W-1:0]  L2,
  input  logic [DATA_W-1:0]  L3,
  output logic [NUM_REQ-1:0] GNT,
  output logic [SEL_W-1:0]   SEL,
  output logic [DATA_W-1:0]  R,
  output logic               VALID
);

  logic [0:0]        state;
  logic [SEL_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt;

  logic              rotate;
  logic [SEL_W-1:0]  next_ptr;
  logic [SEL_W-1:0]  ptr_eff;
  logic [SEL_W-1:0]  pick;
  logic              any;
  logic [DATA_W-1:0] sel_data;

  // Current grantee gives up the path on release or hold expiry; the pointer
  // moves past it and the same edge re-arbitrates with the moved pointer.
  always_comb begin
    next_ptr = SEL + SEL_W'(1);
    rotate   = (state == ST_GRANT) &&
               (!REQ[SEL] || (cnt == CNT_W'(HOLD_CYCLES)));
    ptr_eff  = rotate ? next_ptr : ptr;
  end

  rr_pick4 u_pick (
    .req  (REQ),
    .ptr  (ptr_eff),
    .pick (pick),
    .any  (any)
  );

  // 4:1 data mux on the registered select.
  always_comb begin
    case (SEL)
      2'd0:    sel_data = L0;
      2'd1:    sel_data = L1;
      2'd2:    sel_data = L2;
      default: sel_data = L3;
    endcase
  end

  // Arbitration state, pointer, hold counter, grant and select.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      GNT   <= '0;
      SEL   <= '0;
    end else if (state == ST_IDLE) begin
      if (any) begin
        state <= ST_GRANT;
        GNT   <= onehot4(pick);
        SEL   <= pick;
        cnt   <= CNT_W'(1);
      end
    end else if (!rotate) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      ptr <= next_ptr;
      if (any) begin
        GNT <= onehot4(pick);
        SEL <= pick;
        cnt <= CNT_W'(1);
      end else begin
        state <= ST_IDLE;
        GNT   <= '0;
        cnt   <= '0;
      end
    end
  end

  // Data register: capture the selected lane on every granted cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      R     <= '0;
      VALID <= 1'b0;
    end else if (state == ST_GRANT) begin
      R     <= sel_data;
      VALID <= 1'b1;
    end else begin
      VALID <= 1'b0;
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the team's 4-to-1, 4-bit conditional multiplexer datapath.
- Four requesters share one 4-bit result path.
- The block grants one requester at a time, drives the mux select, and registers the selected data with a valid flag.
- Sits between the requesters and downstream logic that consumes R/VALID.

Parameters:
HOLD_CYCLES, 4, maximum consecutive grant cycles per requester before forced rotation (legal range 1..15).

Ports:
CLK  input  1  system clock; all state changes on rising edge.
RST  input  1  synchronous, active-high reset.
REQ  input  4  request vector; bit i = requester i wants the path; level-sensitive.
L0   input  4  data from requester 0.
L1   input  4  data from requester 1.
L2   input  4  data from requester 2.
L3   input  4  data from requester 3.
GNT  output 4  one-hot grant, registered; all zero when idle.
SEL  output 2  mux select, registered; index of current/last grantee.
R    output 4  registered selected data.
VALID output 1 registered; high when R holds data sampled under a grant.

Behaviour:
- Reset (RST=1 at rising edge):
  - GNT=0, SEL=0, R=0, VALID=0.
  - Round-robin pointer PTR=0, hold counter CNT=0, state IDLE.
  - Reset overrides everything, including mid-grant; no grant survives reset.
- States: IDLE (no grant) and GRANT (GNT one-hot, CNT counts cycles granted).
- Arbitration pick:
  - First i with REQ[i]=1, scanning circularly PTR, PTR+1, ... PTR+3, all mod 4.
  - Purely combinational from REQ and PTR.
- IDLE:
  - REQ=0: stay IDLE; GNT stays 0; SEL holds its last value.
  - REQ≠0: next edge sets GNT=onehot(pick), SEL=pick, CNT=1, state GRANT.
  - Latency from REQ rising to GNT high is 1 cycle.
- GRANT, with current grantee g=SEL:
  - Keep: REQ[g]=1 and CNT<HOLD_CYCLES → keep grant; CNT<=CNT+1.
  - Release: REQ[g]=0 → PTR<=g+1 mod 4. Re-arbitrate on the same edge using the new PTR.
    - If any request remains, grant it immediately (no bubble) with CNT=1.
    - Otherwise GNT<=0 and go to IDLE.
  - Expiry: REQ[g]=1 and CNT==HOLD_CYCLES → PTR<=g+1 mod 4; re-arbitrate as above.
    - If g is the only requester, it is re-granted with CNT=1 (GNT stays high, no gap).
- Data path:
  - On every edge where state was GRANT: R<=L[SEL], VALID<=1.
  - Otherwise: VALID<=0 and R holds.
  - R/VALID therefore lag GNT by exactly 1 cycle.
- Simultaneous requests:
  - Resolved solely by the PTR scan order.
  - A new REQ arriving in the same cycle as a release competes normally.
- Invariants:
  - GNT is always zero or one-hot.
  - GNT never asserts for a requester whose REQ was 0 at the deciding edge.
  - SEL always equals the index of GNT when GNT≠0.
- Fairness: a continuously requesting agent waits at most 3×HOLD_CYCLES cycles for a grant.
- Width rules:
  - CNT is 4 bits.
  - PTR and SEL are 2 bits; increments wrap 3→0.

Decomposition:
- Shared package:
  - state encoding: IDLE=1'b0, GRANT=1'b1.
  - NUM_REQ=4, SEL_W=2, DATA_W=4, CNT_W=4.
- One sub-module, rr_pick4:
  - Inputs: REQ[3:0], PTR[1:0].
  - Outputs: pick index [1:0] and any-request flag.
  - Combinational; reused by future arbiters.

Test Plan:
1. Reset then idle: RST=1 for 2 cycles, REQ=0 → GNT=0, SEL=0, R=0, VALID=0 indefinitely.
2. Single requester: REQ=4'b0100, L2=4'hA, HOLD_CYCLES=4 → GNT=4'b0100 one cycle later and stays high (re-granted on expiry); SEL=2; VALID=1 and R=4'hA from the following cycle.
3. Rotation:
   - Stimulus: REQ=4'b1111 constant, L0..L3 = 1,2,3,4.
   - Required: GNT sequence 0001, 0010, 0100, 1000, each held exactly 4 cycles, no idle gaps.
   - Required: R follows 1,2,3,4 delayed one cycle.
4. Early release handoff: grant on 0, drop REQ[0] after 2 cycles while REQ[3]=1 → GNT goes 0001→1000 on the next edge, no bubble; PTR=1, so subsequent REQ[1] beats REQ[3] after 3 releases.
5. Simultaneous arrival after idle with PTR=2: REQ goes 0→4'b1011 → grant order is 3, then 0, then 1.
6. Reset mid-grant: assert RST while GNT=4'b0010 and VALID=1 → next edge GNT=0, VALID=0, R=0, PTR=0; then REQ=4'b0011 is granted to requester 0 first.
